// File: rtl/mem_cycle_ctrl_pkg.sv
// Shared definitions for the memory-cycle sequencer: op and state encodings,
// default widths, and a small helper used to decide whether a transaction
// returns data to the memory-buffer register.
package mem_cycle_ctrl_pkg;

  localparam int DEF_W       = 12;
  localparam int DEF_TIMEOUT = 15;
  localparam int TMO_W       = 8;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_RIW = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_INC     = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_FIN     = 3'd4
  } state_e;

  // Reads and auto-index cycles hand a word to the MB register; writes and no-ops do not.
  function automatic logic op_returns_data(input op_e o);
    return (o == OP_RD) || (o == OP_RIW);
  endfunction

endpackage

// File: rtl/mem_cycle_ctrl_timeout.sv
// Wait-state watchdog: an 8-bit counter that is cleared outside the wait
// states, counts wait cycles without acknowledge, and flags the cycle in
// which the count reaches LIMIT.
module mc_timeout
  import mem_cycle_ctrl_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TMO_W-1:0] cnt;

  // Count unacknowledged wait cycles; clear whenever the sequencer is not waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + TMO_W'(1);
    end
  end

  // Expiry fires on the increment that would bring the count to LIMIT, so a
  // strobe is held for exactly LIMIT wait cycles; an ack in that cycle suppresses inc.
  assign expired = inc && (cnt == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/mem_cycle_ctrl.sv
// Memory-cycle sequencer feeding the 12-bit memory-buffer latch. Runs one
// read, write or read-increment-write (auto-index) transaction per accepted
// request, handshakes with memory via strobe/ack, and presents a registered
// word plus a one-cycle latch pulse. A hung wait state is aborted with err.
module mem_cycle_ctrl
  import mem_cycle_ctrl_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         req,
  input  logic [1:0]   op,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] rdata,
  output logic         mb_latch,
  output logic [W-1:0] mem_addr,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [W-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [W-1:0] mem_rdata
);

  state_e       state;
  op_e          op_q;
  logic [W-1:0] rdata_inc;
  logic         tmo_clr;
  logic         tmo_inc;
  logic         tmo_expired;

  // Auto-index increment wraps modulo 2^W (07777 -> 0000).
  assign rdata_inc = rdata + W'(1);

  assign tmo_clr = !((state == ST_RD_WAIT) || (state == ST_WR_WAIT));
  assign tmo_inc = !tmo_clr && !mem_ack;

  mc_timeout #(
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  // Transaction FSM with registered strobes, data and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_RD;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mb_latch  <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      mb_latch <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            op_q     <= op_e'(op);
            mem_addr <= addr;
            busy     <= 1'b1;
            case (op_e'(op))
              OP_RD, OP_RIW: begin
                mem_rd <= 1'b1;
                state  <= ST_RD_WAIT;
              end
              OP_WR: begin
                mem_wr    <= 1'b1;
                mem_wdata <= wdata;
                state     <= ST_WR_WAIT;
              end
              default: state <= ST_FIN;
            endcase
          end
        end
        ST_RD_WAIT: begin
          if (mem_ack) begin
            rdata  <= mem_rdata;
            mem_rd <= 1'b0;
            state  <= (op_q == OP_RIW) ? ST_INC : ST_FIN;
          end else if (tmo_expired) begin
            mem_rd <= 1'b0;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_INC: begin
          rdata     <= rdata_inc;
          mem_wdata <= rdata_inc;
          mem_wr    <= 1'b1;
          state     <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (mem_ack) begin
            mem_wr <= 1'b0;
            state  <= ST_FIN;
          end else if (tmo_expired) begin
            mem_wr <= 1'b0;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_FIN: begin
          done     <= 1'b1;
          mb_latch <= op_returns_data(op_q);
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          mem_rd <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cycle_ctrl.sv
// Bench for mem_cycle_ctrl: a behavioural memory with programmable ack delay,
// a scoreboard of expected completions, and directed transaction sequences.
module tb_mem_cycle_ctrl;

  logic        clk, reset_n, req;
  logic [1:0]  op;
  logic [11:0] addr, wdata;
  logic        busy, done, err, mb_latch, mem_rd, mem_wr, mem_ack;
  logic [11:0] rdata, mem_addr, mem_wdata, mem_rdata;

  typedef struct {
    logic        done;
    logic        err;
    logic        latch;
    logic [11:0] rdata;
  } exp_t;

  exp_t        sbq[$];
  logic [11:0] mem [0:4095];
  int          total = 0, bad = 0;
  int          cyc = 0, acc_count = 0, acc_cyc = 0, ev_count = 0, last_lat = 0;
  int          low_run = 0, last_gap = 0, rd_cyc = 0, wr_cyc = 0, wcnt = 0, latch_cnt = 0;
  int          ack_dly = 0;
  bit          rd_ok = 1, wr_ok = 1;
  logic        prev_busy;
  logic [11:0] exp_addr, wb_data, model_rdata;

  mem_cycle_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mb_latch  (mb_latch),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'(0));
    chk({tag, "_done"},  32'(done),      32'(0));
    chk({tag, "_err"},   32'(err),       32'(0));
    chk({tag, "_rdata"}, 32'(rdata),     32'(0));
    chk({tag, "_latch"}, 32'(mb_latch),  32'(0));
    chk({tag, "_maddr"}, 32'(mem_addr),  32'(0));
    chk({tag, "_mrd"},   32'(mem_rd),    32'(0));
    chk({tag, "_mwr"},   32'(mem_wr),    32'(0));
    chk({tag, "_mwd"},   32'(mem_wdata), 32'(0));
  endtask

  // Monitor, scoreboard and memory model, all evaluated on the falling edge.
  initial begin
    exp_t e;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        prev_busy = 1'b0;
        wcnt      = 0;
        mem_ack   = 1'b0;
        low_run   = 0;
      end else begin
        if (busy && !prev_busy) begin
          acc_count++;
          acc_cyc  = cyc;
          last_gap = low_run;
        end
        low_run   = busy ? 0 : low_run + 1;
        prev_busy = busy;
        chk("rd_wr_excl", 32'(mem_rd & mem_wr), 32'(0));
        if (mb_latch) begin
          latch_cnt++;
          chk("latch_with_done", 32'(done), 32'(1));
        end
        if (done || err) begin
          ev_count++;
          last_lat = cyc - acc_cyc;
          if (sbq.size() == 0) begin
            chk("sb_extra", 32'({done, err}), 32'(0));
          end else begin
            e = sbq.pop_front();
            chk("done",  32'(done),     32'(e.done));
            chk("err",   32'(err),      32'(e.err));
            chk("latch", 32'(mb_latch), 32'(e.latch));
            chk("rdata", 32'(rdata),    32'(e.rdata));
          end
        end
        if (mem_rd || mem_wr) begin
          chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
          if (mem_rd) rd_cyc++;
          if (mem_wr) wr_cyc++;
          if (((mem_rd && rd_ok) || (mem_wr && wr_ok)) && (wcnt == ack_dly)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_rd ? mem[mem_addr] : 12'h000;
            if (mem_wr) begin
              mem[mem_addr] = mem_wdata;
              wb_data       = mem_wdata;
            end
          end else begin
            mem_ack = 1'b0;
          end
          wcnt++;
        end else begin
          wcnt      = 0;
          mem_ack   = 1'b0;
          mem_rdata = '0;
        end
      end
    end
  end

  task automatic wait_ev(input int target);
    int n = 0;
    while (ev_count < target && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("ev_wait", 32'(ev_count), 32'(target));
  endtask

  task automatic run_txn(input logic [1:0] o, input logic [11:0] a, input logic [11:0] wd,
                         input int dly, input bit rok, input bit wok, input int hold,
                         input int exp_lat);
    exp_t e;
    int   e0;
    e.done  = 1'b1;
    e.err   = 1'b0;
    e.latch = 1'b0;
    e.rdata = model_rdata;
    case (o)
      2'b00: begin
        if (rok) begin
          e.latch = 1'b1;
          e.rdata = mem[a];
        end else begin
          e.done = 1'b0;
          e.err  = 1'b1;
        end
      end
      2'b01: begin
        if (!wok) begin
          e.done = 1'b0;
          e.err  = 1'b1;
        end
      end
      2'b10: begin
        if (rok) e.rdata = mem[a] + 12'd1;
        if (rok && wok) begin
          e.latch = 1'b1;
        end else begin
          e.done = 1'b0;
          e.err  = 1'b1;
        end
      end
      default: ;
    endcase
    model_rdata = e.rdata;
    sbq.push_back(e);
    ack_dly   = dly;
    rd_ok     = rok;
    wr_ok     = wok;
    exp_addr  = a;
    rd_cyc    = 0;
    wr_cyc    = 0;
    latch_cnt = 0;
    e0        = ev_count;
    @(negedge clk);
    #2;
    req   = 1'b1;
    op    = o;
    addr  = a;
    wdata = wd;
    repeat (hold) begin
      @(negedge clk);
      #2;
    end
    req = 1'b0;
    wait_ev(e0 + 1);
    if (exp_lat >= 0) chk("latency", 32'(last_lat), 32'(exp_lat));
  endtask

  initial begin
    int e0, a0, n;
    reset_n     = 1'b0;
    req         = 1'b0;
    op          = 2'b00;
    addr        = '0;
    wdata       = '0;
    exp_addr    = '0;
    wb_data     = '0;
    model_rdata = '0;
    mem[12'o0200] = 12'o1234;
    mem[12'o0201] = 12'o4321;
    mem[12'o0010] = 12'o7777;
    mem[12'o0011] = 12'o0123;
    mem[12'o0040] = 12'o0500;
    mem[12'o0100] = 12'o0111;
    mem[12'o0101] = 12'o0222;

    repeat (3) @(negedge clk);
    #2;
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read, ack after 3 wait cycles; req held into busy must not start a second cycle.
    e0 = ev_count;
    run_txn(2'b00, 12'o0200, 12'o0000, 3, 1'b1, 1'b1, 3, 5);
    chk("rd_strobe_cycles", 32'(rd_cyc), 32'(4));
    chk("rd_latch_count", 32'(latch_cnt), 32'(1));
    repeat (6) @(negedge clk);
    #2;
    chk("single_txn", 32'(ev_count), 32'(e0 + 1));

    // Read with immediate ack: minimum latency.
    run_txn(2'b00, 12'o0201, 12'o0000, 0, 1'b1, 1'b1, 1, 2);

    // Write, ack after 1 cycle.
    run_txn(2'b01, 12'o0017, 12'o5252, 1, 1'b1, 1'b1, 1, 3);
    chk("wr_strobe_cycles", 32'(wr_cyc), 32'(2));
    chk("wr_data", 32'(wb_data), 32'(12'o5252));
    chk("wr_latch_count", 32'(latch_cnt), 32'(0));

    // Auto-index with wrap, then ordinary increment.
    run_txn(2'b10, 12'o0010, 12'o0000, 0, 1'b1, 1'b1, 1, 4);
    chk("riw_wrap_wb", 32'(wb_data), 32'(12'o0000));
    chk("riw_wrap_latch", 32'(latch_cnt), 32'(1));
    run_txn(2'b10, 12'o0011, 12'o0000, 0, 1'b1, 1'b1, 1, 4);
    chk("riw_wb", 32'(wb_data), 32'(12'o0124));
    chk("riw_latch", 32'(latch_cnt), 32'(1));

    // Reserved op: done only, no memory access.
    run_txn(2'b11, 12'o0300, 12'o0000, 0, 1'b1, 1'b1, 1, 1);
    chk("nop_rd", 32'(rd_cyc + wr_cyc), 32'(0));
    chk("nop_latch", 32'(latch_cnt), 32'(0));

    // Timeout with no ack, then ack landing in the last allowed wait cycle.
    run_txn(2'b00, 12'o0200, 12'o0000, 0, 1'b0, 1'b1, 1, 15);
    chk("tmo_strobe_cycles", 32'(rd_cyc), 32'(15));
    chk("tmo_latch", 32'(latch_cnt), 32'(0));
    run_txn(2'b00, 12'o0200, 12'o0000, 14, 1'b1, 1'b1, 1, 16);
    chk("late_ack_cycles", 32'(rd_cyc), 32'(15));

    // Asynchronous reset during the write phase of an auto-index cycle.
    rd_ok    = 1'b1;
    wr_ok    = 1'b0;
    ack_dly  = 0;
    exp_addr = 12'o0040;
    e0       = ev_count;
    @(negedge clk);
    #2;
    req  = 1'b1;
    op   = 2'b10;
    addr = 12'o0040;
    @(negedge clk);
    #2;
    req = 1'b0;
    n   = 0;
    while (!mem_wr && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("wr_wait_seen", 32'(mem_wr), 32'(1));
    @(negedge clk);
    #2;
    req = 1'b1;
    @(negedge clk);
    #2;
    req = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    repeat (2) @(negedge clk);
    #2;
    reset_n     = 1'b1;
    model_rdata = '0;
    repeat (6) @(negedge clk);
    #2;
    chk("no_evt_after_rst", 32'(ev_count), 32'(e0));
    chk("idle_after_rst", 32'(busy), 32'(0));
    chk("no_wb_after_rst", 32'(mem[12'o0040]), 32'(12'o0500));

    // Back-to-back reads with req held high.
    begin
      exp_t e1, e2;
      e1.done = 1'b1; e1.err = 1'b0; e1.latch = 1'b1; e1.rdata = 12'o0111;
      e2.done = 1'b1; e2.err = 1'b0; e2.latch = 1'b1; e2.rdata = 12'o0222;
      sbq.push_back(e1);
      sbq.push_back(e2);
    end
    model_rdata = 12'o0222;
    rd_ok    = 1'b1;
    wr_ok    = 1'b1;
    ack_dly  = 0;
    exp_addr = 12'o0100;
    a0       = acc_count;
    e0       = ev_count;
    @(negedge clk);
    #2;
    req  = 1'b1;
    op   = 2'b00;
    addr = 12'o0100;
    n    = 0;
    while (acc_count < a0 + 1 && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    addr     = 12'o0101;
    exp_addr = 12'o0101;
    while (acc_count < a0 + 2 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    req = 1'b0;
    chk("b2b_accepts", 32'(acc_count), 32'(a0 + 2));
    wait_ev(e0 + 2);
    chk("busy_gap", 32'(last_gap), 32'(1));

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
